// File: rtl/sram_read_responder_pkg.sv
// Shared AXI definitions for the SRAM read responder: bus widths, burst and
// response encodings, and the responder FSM state type.

`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif

package sram_read_responder_pkg;

  // AXI burst type encodings; 2'b11 is reserved and handled like INCR
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // AXI read response encodings
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    RESP
  } state_t;

  // Beats wider than the 32-bit data path cannot be served correctly, so
  // they are flagged as slave errors while the data is still returned.
  function automatic logic [1:0] size_resp(input logic [`AXI_SIZE_BITS-1:0] size);
    return (size <= `AXI_SIZE_BITS'(2)) ? RESP_OKAY : RESP_SLVERR;
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next-word-address calculation for an AXI read burst. FIXED bursts hold
// the address; INCR, WRAP and the reserved encoding step one word. The
// address simply rolls over at the top of the SRAM window.

module axi_burst_addr_gen
  import sram_read_responder_pkg::*;
#(
  parameter int AW = 14
) (
  input  logic [AW-1:0] addr,
  input  logic [1:0]    burst,
  input  logic          advance,
  output logic [AW-1:0] next_addr
);

  // Pick the following word address; unchanged unless advancing
  always_comb begin
    next_addr = addr;
    if (advance) begin
      case (burst)
        BURST_FIXED:           next_addr = addr;
        BURST_INCR, BURST_WRAP: next_addr = addr + AW'(1);
        default:               next_addr = addr + AW'(1);
      endcase
    end
  end

endmodule

// File: rtl/sram_read_responder.sv
// AXI read-channel slave in front of a single-port, read-latency-1 SRAM.
// Each beat costs one FETCH cycle (SRAM strobed) and at least one RESP cycle
// (beat presented until the master takes it).

module sram_read_responder
  import sram_read_responder_pkg::*;
#(
  parameter int SRAM_AW = 14,
  parameter int LAT     = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [`AXI_IDS_BITS-1:0]   ARID,
  input  logic [`AXI_ADDR_BITS-1:0]  ARADDR,
  input  logic [`AXI_LEN_BITS-1:0]   ARLEN,
  input  logic [`AXI_SIZE_BITS-1:0]  ARSIZE,
  input  logic [1:0]                 ARBURST,
  input  logic                       ARVALID,
  output logic                       ARREADY,
  output logic [`AXI_IDS_BITS-1:0]   RID,
  output logic [`AXI_DATA_BITS-1:0]  RDATA,
  output logic [1:0]                 RRESP,
  output logic                       RLAST,
  output logic                       RVALID,
  input  logic                       RREADY,
  output logic                       CEB,
  output logic                       WEB,
  output logic [SRAM_AW-1:0]         A,
  input  logic [`AXI_DATA_BITS-1:0]  DO
);

  state_t                    r_state;
  logic [SRAM_AW-1:0]        r_addr;
  logic [`AXI_LEN_BITS-1:0]  r_len;
  logic [`AXI_LEN_BITS-1:0]  r_beatCnt;
  logic [`AXI_SIZE_BITS-1:0] r_size;
  logic [1:0]                r_burst;
  logic [`AXI_IDS_BITS-1:0]  r_rid;
  logic [`AXI_DATA_BITS-1:0] r_rdata;
  logic [1:0]                r_rresp;
  logic                      r_rlast;
  logic                      r_rvalid;
  logic                      r_arready;
  logic                      r_ceb;
  logic [SRAM_AW-1:0]        r_a;

  logic                      w_advance;
  logic [SRAM_AW-1:0]        w_nextAddr;
  logic [SRAM_AW-1:0]        w_reqAddr;
  logic                      w_unused;

  // Byte address to SRAM word address; low byte-lane bits and bits above
  // the window are ignored, as is the fixed latency parameter.
  assign w_reqAddr = ARADDR[SRAM_AW+1:2];
  assign w_unused  = ^{ARADDR[`AXI_ADDR_BITS-1:SRAM_AW+2], ARADDR[1:0], LAT[0]};

  // Only step the address when a non-final beat is being accepted
  assign w_advance = (r_state == RESP) && RREADY && !r_rlast;

  axi_burst_addr_gen #(
    .AW(SRAM_AW)
  ) u_addrGen (
    .addr     (r_addr),
    .burst    (r_burst),
    .advance  (w_advance),
    .next_addr(w_nextAddr)
  );

  // Request capture, SRAM strobe and beat presentation, all registered
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_len     <= '0;
      r_beatCnt <= '0;
      r_size    <= '0;
      r_burst   <= '0;
      r_rid     <= '0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
      r_rlast   <= 1'b0;
      r_rvalid  <= 1'b0;
      r_arready <= 1'b1;
      r_ceb     <= 1'b1;
      r_a       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (ARVALID) begin
            r_rid     <= ARID;
            r_addr    <= w_reqAddr;
            r_len     <= ARLEN;
            r_size    <= ARSIZE;
            r_burst   <= ARBURST;
            r_beatCnt <= '0;
            r_arready <= 1'b0;
            r_ceb     <= 1'b0;
            r_a       <= w_reqAddr;
            r_state   <= FETCH;
          end
        end
        FETCH: begin
          r_ceb    <= 1'b1;
          r_rdata  <= DO;
          r_rresp  <= size_resp(r_size);
          r_rlast  <= (r_beatCnt == r_len);
          r_rvalid <= 1'b1;
          r_state  <= RESP;
        end
        RESP: begin
          if (RREADY) begin
            r_rvalid <= 1'b0;
            if (r_rlast) begin
              r_rlast   <= 1'b0;
              r_arready <= 1'b1;
              r_state   <= IDLE;
            end else begin
              r_beatCnt <= r_beatCnt + `AXI_LEN_BITS'(1);
              r_addr    <= w_nextAddr;
              r_a       <= w_nextAddr;
              r_ceb     <= 1'b0;
              r_state   <= FETCH;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ARREADY = r_arready;
  assign RID     = r_rid;
  assign RDATA   = r_rdata;
  assign RRESP   = r_rresp;
  assign RLAST   = r_rlast;
  assign RVALID  = r_rvalid;
  assign CEB     = r_ceb;
  assign WEB     = 1'b1;
  assign A       = r_a;

endmodule

// File: tb/tb_sram_read_responder.sv
// Bench for sram_read_responder: a behavioural SRAM, a scoreboard of
// expected SRAM addresses and R beats, and one task per scenario.

module tb_sram_read_responder;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic [`AXI_IDS_BITS-1:0]   ARID = '0;
  logic [`AXI_ADDR_BITS-1:0]  ARADDR = '0;
  logic [`AXI_LEN_BITS-1:0]   ARLEN = '0;
  logic [`AXI_SIZE_BITS-1:0]  ARSIZE = '0;
  logic [1:0]                 ARBURST = '0;
  logic                       ARVALID = 1'b0;
  logic                       ARREADY;
  logic [`AXI_IDS_BITS-1:0]   RID;
  logic [`AXI_DATA_BITS-1:0]  RDATA;
  logic [1:0]                 RRESP;
  logic                       RLAST;
  logic                       RVALID;
  logic                       RREADY = 1'b1;
  logic                       CEB;
  logic                       WEB;
  logic [13:0]                A;
  logic [`AXI_DATA_BITS-1:0]  DO;

  logic [`AXI_DATA_BITS-1:0]  mem [0:16383];

  typedef struct {
    logic [`AXI_DATA_BITS-1:0] data;
    logic [`AXI_IDS_BITS-1:0]  id;
    logic [1:0]                resp;
    logic                      last;
  } beat_t;

  beat_t       expBeats[$];
  logic [13:0] expAddr[$];
  int          nVectors = 0;
  int          nMiscompares = 0;
  logic        monEn = 1'b0;

  always #5 clk = ~clk;

  sram_read_responder #(
    .SRAM_AW(14),
    .LAT    (1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ARID   (ARID),
    .ARADDR (ARADDR),
    .ARLEN  (ARLEN),
    .ARSIZE (ARSIZE),
    .ARBURST(ARBURST),
    .ARVALID(ARVALID),
    .ARREADY(ARREADY),
    .RID    (RID),
    .RDATA  (RDATA),
    .RRESP  (RRESP),
    .RLAST  (RLAST),
    .RVALID (RVALID),
    .RREADY (RREADY),
    .CEB    (CEB),
    .WEB    (WEB),
    .A      (A),
    .DO     (DO)
  );

  // Read data is only meaningful while the chip is enabled
  assign DO = (!CEB) ? mem[A] : 32'hDEAD_BEEF;

  // Scoreboard: every SRAM strobe and every accepted beat is popped and checked
  always @(negedge clk) begin
    beat_t       e;
    logic [13:0] ea;
    if (monEn && !rst) begin
      if (CEB === 1'b0) begin
        nVectors++;
        if (expAddr.size() == 0) begin
          nMiscompares++;
          $display("[TB] FAIL sram_strobe: unexpected access A=%h, want none", A);
        end else begin
          ea = expAddr.pop_front();
          if (A !== ea) begin
            nMiscompares++;
            $display("[TB] FAIL sram_addr: got A=%h want %h", A, ea);
          end
        end
      end
      if (RVALID === 1'b1 && RREADY === 1'b1) begin
        nVectors++;
        if (expBeats.size() == 0) begin
          nMiscompares++;
          $display("[TB] FAIL r_beat: unexpected beat RDATA=%h, want none", RDATA);
        end else begin
          e = expBeats.pop_front();
          if (RDATA !== e.data || RID !== e.id || RRESP !== e.resp || RLAST !== e.last) begin
            nMiscompares++;
            $display("[TB] FAIL r_beat: got data=%h id=%h resp=%b last=%b want data=%h id=%h resp=%b last=%b",
                     RDATA, RID, RRESP, RLAST, e.data, e.id, e.resp, e.last);
          end
        end
      end
    end
  end

  // Model the burst into the scoreboard, then perform the AR handshake
  task automatic issue_burst(input logic [`AXI_IDS_BITS-1:0] id,
                             input logic [`AXI_ADDR_BITS-1:0] addr,
                             input logic [`AXI_LEN_BITS-1:0] len,
                             input logic [`AXI_SIZE_BITS-1:0] size,
                             input logic [1:0] burst);
    logic [13:0] w;
    beat_t       b;
    w = addr[15:2];
    for (int i = 0; i <= int'(len); i++) begin
      expAddr.push_back(w);
      b.data = mem[w];
      b.id   = id;
      b.resp = (size > 3'd2) ? 2'b10 : 2'b00;
      b.last = (i == int'(len));
      expBeats.push_back(b);
      if (burst != 2'b00) w = w + 14'd1;
    end
    @(posedge clk);
    #1;
    ARVALID = 1'b1;
    ARID    = id;
    ARADDR  = addr;
    ARLEN   = len;
    ARSIZE  = size;
    ARBURST = burst;
    @(posedge clk);
    #1;
    ARVALID = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nVectors++; if (ARREADY !== 1'b1) begin nMiscompares++; $display("[TB] FAIL reset_arready: got %b want 1", ARREADY); end
    nVectors++; if (RVALID !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_rvalid: got %b want 0", RVALID); end
    nVectors++; if (RLAST !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_rlast: got %b want 0", RLAST); end
    nVectors++; if (RRESP !== 2'b00) begin nMiscompares++; $display("[TB] FAIL reset_rresp: got %b want 00", RRESP); end
    nVectors++; if (RDATA !== '0) begin nMiscompares++; $display("[TB] FAIL reset_rdata: got %h want 0", RDATA); end
    nVectors++; if (RID !== '0) begin nMiscompares++; $display("[TB] FAIL reset_rid: got %h want 0", RID); end
    nVectors++; if (CEB !== 1'b1) begin nMiscompares++; $display("[TB] FAIL reset_ceb: got %b want 1", CEB); end
    nVectors++; if (WEB !== 1'b1) begin nMiscompares++; $display("[TB] FAIL reset_web: got %b want 1", WEB); end
    nVectors++; if (A !== 14'h0) begin nMiscompares++; $display("[TB] FAIL reset_a: got %h want 0", A); end
    rst = 1'b0;
    monEn = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      nVectors++;
      if (ARREADY !== 1'b1 || RVALID !== 1'b0 || CEB !== 1'b1) begin
        nMiscompares++;
        $display("[TB] FAIL idle_cycle%0d: got arready=%b rvalid=%b ceb=%b want 1 0 1", c, ARREADY, RVALID, CEB);
      end
    end
  endtask

  task automatic test_incr();
    RREADY = 1'b1;
    issue_burst(8'h25, 32'h10, 4'd3, 3'd2, 2'b01);
    @(negedge clk);
    nVectors++;
    if (RVALID !== 1'b0 || CEB !== 1'b0 || ARREADY !== 1'b0) begin
      nMiscompares++;
      $display("[TB] FAIL incr_fetch_cycle: got rvalid=%b ceb=%b arready=%b want 0 0 0", RVALID, CEB, ARREADY);
    end
    @(negedge clk);
    nVectors++;
    if (RVALID !== 1'b1) begin nMiscompares++; $display("[TB] FAIL incr_first_latency: got rvalid=%b want 1", RVALID); end
    for (int c = 0; c < 100 && (expBeats.size() != 0 || expAddr.size() != 0); c++) @(negedge clk);
    nVectors++;
    if (expBeats.size() != 0 || expAddr.size() != 0) begin
      nMiscompares++;
      $display("[TB] FAIL incr_drain: got %0d beats %0d strobes outstanding want 0", expBeats.size(), expAddr.size());
    end
  endtask

  task automatic test_fixed();
    RREADY = 1'b1;
    issue_burst(8'h11, 32'h8, 4'd2, 3'd2, 2'b00);
    for (int c = 0; c < 100 && (expBeats.size() != 0 || expAddr.size() != 0); c++) @(negedge clk);
    nVectors++;
    if (expBeats.size() != 0 || expAddr.size() != 0) begin
      nMiscompares++;
      $display("[TB] FAIL fixed_drain: got %0d beats %0d strobes outstanding want 0", expBeats.size(), expAddr.size());
    end
  endtask

  task automatic test_stall();
    RREADY = 1'b1;
    issue_burst(8'h3C, 32'h40, 4'd3, 3'd2, 2'b01);
    @(negedge clk);
    for (int c = 0; c < 20 && RVALID !== 1'b1; c++) @(negedge clk);
    @(posedge clk);
    #1;
    RREADY = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 20 && RVALID !== 1'b1; c++) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      nVectors++;
      if (RVALID !== 1'b1 || RDATA !== mem[17] || RLAST !== 1'b0 || RID !== 8'h3C || CEB !== 1'b1) begin
        nMiscompares++;
        $display("[TB] FAIL stall_hold%0d: got rvalid=%b data=%h last=%b id=%h ceb=%b want 1 %h 0 3c 1",
                 k, RVALID, RDATA, RLAST, RID, CEB, mem[17]);
      end
    end
    @(posedge clk);
    #1;
    RREADY = 1'b1;
    for (int c = 0; c < 100 && (expBeats.size() != 0 || expAddr.size() != 0); c++) @(negedge clk);
    nVectors++;
    if (expBeats.size() != 0 || expAddr.size() != 0) begin
      nMiscompares++;
      $display("[TB] FAIL stall_drain: got %0d beats %0d strobes outstanding want 0", expBeats.size(), expAddr.size());
    end
  endtask

  task automatic test_boundary();
    RREADY = 1'b1;
    issue_burst(8'h07, 32'hFFFC, 4'd1, 3'd2, 2'b01);
    for (int c = 0; c < 100 && (expBeats.size() != 0 || expAddr.size() != 0); c++) @(negedge clk);
    issue_burst(8'h08, 32'hFFFC, 4'd1, 3'd3, 2'b01);
    for (int c = 0; c < 100 && (expBeats.size() != 0 || expAddr.size() != 0); c++) @(negedge clk);
    issue_burst(8'h09, 32'h100, 4'd2, 3'd1, 2'b11);
    for (int c = 0; c < 100 && (expBeats.size() != 0 || expAddr.size() != 0); c++) @(negedge clk);
    issue_burst(8'h0A, 32'h200, 4'd1, 3'd2, 2'b10);
    for (int c = 0; c < 100 && (expBeats.size() != 0 || expAddr.size() != 0); c++) @(negedge clk);
    nVectors++;
    if (expBeats.size() != 0 || expAddr.size() != 0) begin
      nMiscompares++;
      $display("[TB] FAIL boundary_drain: got %0d beats %0d strobes outstanding want 0", expBeats.size(), expAddr.size());
    end
  endtask

  task automatic test_reset_mid_burst();
    RREADY = 1'b1;
    issue_burst(8'h5E, 32'h300, 4'd7, 3'd2, 2'b01);
    for (int c = 0; c < 50 && expBeats.size() > 6; c++) @(negedge clk);
    @(posedge clk);
    #1;
    RREADY = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 20 && RVALID !== 1'b1; c++) @(negedge clk);
    nVectors++;
    if (RVALID !== 1'b1 || expBeats.size() != 6) begin
      nMiscompares++;
      $display("[TB] FAIL midrst_reach_beat2: got rvalid=%b pending=%0d want 1 6", RVALID, expBeats.size());
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    expBeats.delete();
    expAddr.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    RREADY = 1'b1;
    @(negedge clk);
    nVectors++;
    if (RVALID !== 1'b0 || ARREADY !== 1'b1) begin
      nMiscompares++;
      $display("[TB] FAIL midrst_after: got rvalid=%b arready=%b want 0 1", RVALID, ARREADY);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      nVectors++;
      if (RVALID !== 1'b0 || CEB !== 1'b1) begin
        nMiscompares++;
        $display("[TB] FAIL midrst_quiet%0d: got rvalid=%b ceb=%b want 0 1", c, RVALID, CEB);
      end
    end
    issue_burst(8'h61, 32'h44, 4'd0, 3'd2, 2'b01);
    for (int c = 0; c < 100 && (expBeats.size() != 0 || expAddr.size() != 0); c++) @(negedge clk);
    nVectors++;
    if (expBeats.size() != 0 || expAddr.size() != 0) begin
      nMiscompares++;
      $display("[TB] FAIL midrst_single_drain: got %0d beats %0d strobes outstanding want 0", expBeats.size(), expAddr.size());
    end
  endtask

  // Scenario sequence with an SRAM image where every word is distinct
  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'h5A00_0000 | 32'(i);
    mem[4] = 32'hA0;
    mem[5] = 32'hA1;
    mem[6] = 32'hA2;
    mem[7] = 32'hA3;
    mem[2] = 32'hB2;
    test_reset();
    test_incr();
    test_fixed();
    test_stall();
    test_boundary();
    test_reset_mid_burst();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
